// File: rtl/mux_2b2_4_pkg.sv
// Shared widths and data type for the mux_2b2_4 operand/result select cell.
// Optional build macro referenced by users of this package: MUX_2B2_4_SEL_CNT_EN.
package mux_2b2_4_pkg;

   localparam int DEFAULT_WIDTH     = 2;
   localparam int DEFAULT_CNT_WIDTH = 8;

   typedef logic [DEFAULT_WIDTH-1:0] mux_data_t;

endpackage

// File: rtl/mux_2b2_4_cell.sv
// Pure combinational WIDTH-bit 2:1 select; anything other than s==1 picks a.
module mux_2b2_4_cell
   import mux_2b2_4_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] r
);

   // An if (rather than ?:) sends an unknown select to the a branch
   // instead of merging a and b into X bits.
   always_comb begin
      r = a;
      if (s == 1'b1) begin
         r = b;
      end
   end

endmodule

// File: rtl/mux_2b2_4.sv
// 2:1 select with a registered copy; define MUX_2B2_4_SEL_CNT_EN to add a
// saturating counter of select transitions on sel_toggles.
module mux_2b2_4
   import mux_2b2_4_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
`ifdef MUX_2B2_4_SEL_CNT_EN
   , parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 s,
   output logic [WIDTH-1:0]     r,
`ifdef MUX_2B2_4_SEL_CNT_EN
   output logic [CNT_WIDTH-1:0] sel_toggles,
`endif
   output logic [WIDTH-1:0]     r_q
);

   mux_2b2_4_cell #(
      .WIDTH (WIDTH)
   ) u_cell (
      .a (a),
      .b (b),
      .s (s),
      .r (r)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else begin
         r_q <= r;
      end
   end

`ifdef MUX_2B2_4_SEL_CNT_EN
   logic s_d;

   // s_d resets to 0, so a high select on the first live cycle counts once.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_d         <= 1'b0;
         sel_toggles <= '0;
      end else begin
         s_d <= s;
         if ((s != s_d) && !(&sel_toggles)) begin
            sel_toggles <= sel_toggles + 1'b1;
         end
      end
   end
`else
   // Plain build: no select-toggle counter.
`endif

endmodule

// File: tb/tb_mux_2b2_4.sv
// Self-checking bench for mux_2b2_4 (build with +define+MUX_2B2_4_SEL_CNT_EN for the counter).
module tb_mux_2b2_4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] a;
   logic [1:0] b;
   logic       s;
   logic [1:0] r;
   logic [1:0] r_q;
`ifdef MUX_2B2_4_SEL_CNT_EN
   logic [7:0] sel_toggles;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   logic [1:0] exp_q[$];
   logic [1:0] exp_v;

   mux_2b2_4 #(
      .WIDTH (2)
`ifdef MUX_2B2_4_SEL_CNT_EN
      , .CNT_WIDTH (8)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .b           (b),
      .s           (s),
      .r           (r),
`ifdef MUX_2B2_4_SEL_CNT_EN
      .sel_toggles (sel_toggles),
`endif
      .r_q         (r_q)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_comb();
      a = 2'd0; b = 2'd0; s = 1'b0;
      for (int si = 0; si < 2; si++) begin
         for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
               s = si[0]; a = ai[1:0]; b = bi[1:0];
               exp_q.push_back(si[0] ? bi[1:0] : ai[1:0]);
               #10;
               exp_v = exp_q.pop_front();
               tests_run++;
               if (r !== exp_v) begin
                  tests_failed++;
                  $display("FAIL comb s=%0d a=%0d b=%0d: r=%0d expected %0d", si, ai, bi, r, exp_v);
               end
               $display("[TB] comb s=%0d a=%0d b=%0d r=%0d", si, ai, bi, r);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; a = 2'd3; b = 2'd0; s = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(2'd0);
         tick();
         exp_v = exp_q.pop_front();
         tests_run++;
         if (r_q !== exp_v || r !== 2'd3) begin
            tests_failed++;
            $display("FAIL reset_hold cyc=%0d: r_q=%0d r=%0d expected r_q=%0d r=3", i, r_q, r, exp_v);
         end
         $display("[TB] reset cyc=%0d r_q=%0d r=%0d", i, r_q, r);
      end
      rst_n = 1'b1;
      exp_q.push_back(2'd3);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if (r_q !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_release: r_q=%0d expected %0d", r_q, exp_v);
      end
      $display("[TB] reset release r_q=%0d", r_q);
   endtask

   task automatic test_latency();
      a = 2'd1; b = 2'd2; s = 1'b0;
      tick();
      s = 1'b1;
      #1;
      tests_run++;
      if (r !== 2'd2 || r_q !== 2'd1) begin
         tests_failed++;
         $display("FAIL latency_pre: r=%0d r_q=%0d expected r=2 r_q=1", r, r_q);
      end
      $display("[TB] latency pre-edge r=%0d r_q=%0d", r, r_q);
      exp_q.push_back(2'd2);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if (r_q !== exp_v) begin
         tests_failed++;
         $display("FAIL latency_post: r_q=%0d expected %0d", r_q, exp_v);
      end
      $display("[TB] latency post-edge r_q=%0d", r_q);
   endtask

   task automatic test_midrun_reset();
      rst_n = 1'b0;
      exp_q.push_back(2'd0);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if (r_q !== exp_v || r !== 2'd2) begin
         tests_failed++;
         $display("FAIL midrun_reset: r_q=%0d r=%0d expected r_q=%0d r=2", r_q, r, exp_v);
      end
      $display("[TB] midrun reset r_q=%0d r=%0d", r_q, r);
      rst_n = 1'b1;
      exp_q.push_back(2'd2);
      tick();
      exp_v = exp_q.pop_front();
      tests_run++;
      if (r_q !== exp_v) begin
         tests_failed++;
         $display("FAIL midrun_release: r_q=%0d expected %0d", r_q, exp_v);
      end
      $display("[TB] midrun release r_q=%0d", r_q);
   endtask

   task automatic test_equal_inputs();
      a = 2'd2; b = 2'd2;
      for (int i = 0; i < 4; i++) begin
         s = ~s;
         #1;
         tests_run++;
         if (r !== 2'd2) begin
            tests_failed++;
            $display("FAIL equal_inputs s=%0b: r=%0d expected 2", s, r);
         end
         $display("[TB] equal s=%0b r=%0d", s, r);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         a = 2'($urandom_range(0, 3));
         b = 2'($urandom_range(0, 3));
         s = 1'($urandom_range(0, 1));
         exp_q.push_back(s ? b : a);
         tick();
         exp_v = exp_q.pop_front();
         tests_run++;
         if (r_q !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b cyc=%0d: r_q=%0d expected %0d", i, r_q, exp_v);
         end
         $display("[TB] b2b cyc=%0d a=%0d b=%0d s=%0b r_q=%0d", i, a, b, s, r_q);
      end
   endtask

`ifdef MUX_2B2_4_SEL_CNT_EN
   task automatic test_sel_counter();
      int exp_cnt;
      s = 1'b0; rst_n = 1'b0;
      tick();
      tests_run++;
      if (sel_toggles !== 8'd0) begin
         tests_failed++;
         $display("FAIL cnt_reset0: sel_toggles=%0d expected 0", sel_toggles);
      end
      rst_n = 1'b1;
      exp_cnt = 0;
      for (int i = 1; i <= 300; i++) begin
         s = ~s;
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         tick();
         if (i == 1 || i == 100 || i == 255 || i == 256 || i == 300) begin
            tests_run++;
            if (sel_toggles !== exp_cnt[7:0]) begin
               tests_failed++;
               $display("FAIL cnt_toggle i=%0d: sel_toggles=%0d expected %0d", i, sel_toggles, exp_cnt);
            end
            $display("[TB] cnt i=%0d sel_toggles=%0d", i, sel_toggles);
         end
      end
      rst_n = 1'b0;
      tick();
      tests_run++;
      if (sel_toggles !== 8'd0) begin
         tests_failed++;
         $display("FAIL cnt_reset1: sel_toggles=%0d expected 0", sel_toggles);
      end
      $display("[TB] cnt after reset sel_toggles=%0d", sel_toggles);
      rst_n = 1'b1;
   endtask
`endif

   task automatic test_x_select();
      a = 2'd1; b = 2'd2; s = 1'bx;
      #1;
      // Only a genuine 1 selects b; a 2-state simulator may resolve the X to 0.
      exp_v = (s === 1'b1) ? b : a;
      tests_run++;
      if (r !== exp_v) begin
         tests_failed++;
         $display("FAIL x_select: r=%0d expected %0d", r, exp_v);
      end
      $display("[TB] x_select r=%0d", r);
      s = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; a = 2'd0; b = 2'd0; s = 1'b0;
      test_comb();
      test_reset();
      test_latency();
      test_midrun_reset();
      test_equal_inputs();
      test_back_to_back();
`ifdef MUX_2B2_4_SEL_CNT_EN
      test_sel_counter();
`endif
      test_x_select();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
